ahb_lite_slave: RTL and testbench
=================================

# ahb_lite_slave

AHB-Lite slave that maps a word-organised on-chip memory onto the AHB-Lite bus. It sits behind the system's AHB interface bundle as the single slave attached to the master/BFM. It accepts byte, halfword and word transfers with zero wait states by default. Illegal accesses complete with the two-cycle ERROR response.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of HADDR
- DATA_WIDTH, 32, width of HWDATA/HRDATA (fixed 32; other values unsupported)
- MEM_DEPTH, 1024, number of 32-bit words; valid byte addresses are 0 to 4*MEM_DEPTH-1

Ports:
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset; synchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  byte address (address phase)
- HWRITE  in  1  1=write, 0=read
- HSIZE  in  3  0=byte, 1=halfword, 2=word
- HBURST  in  3  burst type; accepted, not used for decoding
- HPROT  in  4  protection; ignored
- HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus-level ready (previous transfer complete)
- HWDATA  in  DATA_WIDTH  write data (data phase)
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

## Operation
- **Address phase sampling.** On a rising edge with HSEL=1, HREADY=1 and HTRANS=NONSEQ or SEQ, register HADDR, HWRITE, HSIZE and an active flag.
  - Any other condition with HREADY=1 clears the active flag.
  - IDLE and BUSY get an OKAY, zero-wait response.
- **Legality check**, evaluated on the sampled address. A transfer is illegal if any of these holds; otherwise it is legal:
  - HADDR ≥ 4*MEM_DEPTH
  - HSIZE > 2
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]≠0
- **Legal write.** Commits to mem[HADDR>>2] at the end of the completing data-phase cycle, using little-endian byte lanes:
  - byte: lane HADDR[1:0]
  - halfword: lanes HADDR[1]*2 and HADDR[1]*2+1
  - word: all 4 lanes
  - Unselected lanes are unchanged.
- **Legal read.** HRDATA = mem[registered addr>>2], full word; the master selects lanes.
  - HRDATA is combinational from the registered address during an active read data phase, and 0 otherwise.
- **Illegal transfer.** Two-cycle ERROR response; no memory update; HRDATA=0.
  - Data-phase cycle 1: HREADYOUT=0, HRESP=1.
  - Data-phase cycle 2: HREADYOUT=1, HRESP=1.
- **Response FSM** has three states: OKAY, ERR1, ERR2.
  - OKAY → ERR1 when an illegal transfer is sampled.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 if the address phase overlapping ERR2 is sampled as illegal; ERR2 → OKAY otherwise.
  - Address phases are sampled only when HREADY=1.
- **Reset.** HRESETn=0 at a rising edge:
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM to OKAY; active flag cleared.
  - All memory words cleared to 0.
  - A transfer in flight is discarded; its write is not committed.

## Timing
- Zero-wait OKAY transfers take 1 address cycle plus 1 data cycle and can be pipelined back-to-back every cycle.
- Read-after-write to the same address in consecutive transfers returns the new data, because the write commits before the read's data phase.
- When HREADY=0 (another slave is stalling), no new address phase is sampled and the slave's registered state holds.
- HRESP and HREADYOUT are registered outputs; HRDATA is combinational from registers and memory.

## Configuration
- **Macro: AHB_LITE_SLAVE_WAIT_STATE_EN.**
- **Defined:** every legal NONSEQ/SEQ transfer inserts exactly one wait state.
  - First data-phase cycle: HREADYOUT=0, HRESP=0.
  - Second cycle: HREADYOUT=1.
  - HWDATA is sampled and the write committed on the second cycle only.
  - Read data is valid on the second cycle.
  - Error responses are unchanged.
- **Undefined:** zero-wait behaviour as above.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles → HREADYOUT=1, HRESP=0, HRDATA=0; word read of 0x0 returns 0x00000000.
- Word write 0xDEADBEEF to 0x10, then word read 0x10 back-to-back → HRDATA=0xDEADBEEF with OKAY on both transfers.
- Byte writes 0x11/0x22/0x33/0x44 to 0x20–0x23, halfword write 0xAAAA to 0x22, word read 0x20 → 0xAAAA2211.
- Read at 4*MEM_DEPTH (0x1000) → cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1; next word read at 0x0 → OKAY.
- Misaligned word write 0x12345678 to 0x31 → two-cycle ERROR; word read 0x30 → 0x00000000.
- With AHB_LITE_SLAVE_WAIT_STATE_EN: word write 0xCAFEF00D to 0x40 → one cycle with HREADYOUT=0; read back → 0xCAFEF00D after one wait state.

Source files
------------

// File: rtl/ahb_lite_slave.sv
// ahb_lite_slave
// AHB-Lite slave mapping a word-organised on-chip memory onto the bus.
// Byte, halfword and word transfers complete with zero wait states.
// Illegal accesses (out of range, bad size, misaligned) get the two-cycle
// ERROR response and never touch memory.
//
// Optional feature macro: AHB_LITE_SLAVE_WAIT_STATE_EN
//   When defined, every legal NONSEQ/SEQ transfer inserts exactly one wait
//   state. Write data is taken and read data is presented on the second
//   data-phase cycle.
//
// Ports:
//   HCLK       bus clock, all logic on the rising edge
//   HRESETn    synchronous active-low reset (also clears the memory)
//   HSEL       slave select
//   HADDR      byte address (address phase)
//   HWRITE     1 = write, 0 = read
//   HSIZE      0 = byte, 1 = halfword, 2 = word
//   HBURST     accepted, not decoded
//   HPROT      ignored
//   HTRANS     0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
//   HMASTLOCK  ignored
//   HREADY     bus-level ready (previous transfer complete)
//   HWDATA     write data (data phase)
//   HRDATA     read data, combinational from registers and memory
//   HREADYOUT  registered slave ready
//   HRESP      registered response, 0 = OKAY, 1 = ERROR
module ahb_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  // ST_WAIT is only reachable when the wait-state feature is built in.
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  ready_s;
  logic                  resp_s;

  logic                  sample_s;
  logic                  legal_s;
  logic                  commit_s;

  logic                  active_r;
  logic                  write_r;
  logic                  legal_r;
  logic [2:0]            size_r;
  logic [IDX_W+1:0]      addr_r;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Transfer attributes that only matter for protocol features this slave
  // does not implement.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Legality of an address-phase request: in range and naturally aligned.
  function automatic logic is_legal(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [2:0]            size);
    logic align_ok;
    case (size)
      3'd0:    align_ok = 1'b1;
      3'd1:    align_ok = (addr[0] == 1'b0);
      3'd2:    align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    return ({1'b0, addr} < MEM_BYTES) && align_ok;
  endfunction

  // Little-endian byte-lane enables for a write of the given size.
  function automatic logic [3:0] lane_mask(input logic [1:0] addr,
                                           input logic [2:0] size);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << addr;
      3'd1:    mask = addr[1] ? 4'b1100 : 4'b0011;
      3'd2:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  assign sample_s = HSEL && HREADY && HTRANS[1];
  assign legal_s  = is_legal(HADDR, HSIZE);

  // A write commits only on the data-phase cycle that actually completes;
  // in the wait-state build that is the cycle after the stall.
  assign commit_s = active_r && write_r && legal_r && HREADY && HREADYOUT;

  // Address-phase capture; holds whenever the bus is stalled.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      active_r <= 1'b0;
      write_r  <= 1'b0;
      legal_r  <= 1'b0;
      size_r   <= 3'd0;
      addr_r   <= '0;
    end else if (HREADY) begin
      active_r <= sample_s;
      if (sample_s) begin
        write_r <= HWRITE;
        legal_r <= legal_s;
        size_r  <= HSIZE;
        addr_r  <= HADDR[IDX_W+1:0];
      end
    end
  end

  // Memory array: cleared on reset, lane-masked write on commit.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit_s) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask(addr_r[1:0], size_r)[l]) begin
          mem[addr_r[IDX_W+1:2]][8*l +: 8] <= HWDATA[8*l +: 8];
        end
      end
    end
  end

  // Response FSM state register; outputs are registered alongside it.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r   <= ST_OKAY;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      HREADYOUT <= ready_s;
      HRESP     <= resp_s;
    end
  end

  // Response FSM next-state logic.
  always_comb begin
    next_state_s = ST_OKAY;
    case (state_r)
      ST_OKAY, ST_ERR2: begin
        if (sample_s && !legal_s) begin
          next_state_s = ST_ERR1;
        end else if (sample_s) begin
`ifdef AHB_LITE_SLAVE_WAIT_STATE_EN
          next_state_s = ST_WAIT;
`else
          next_state_s = ST_OKAY;
`endif
        end else begin
          next_state_s = ST_OKAY;
        end
      end
      ST_ERR1: next_state_s = ST_ERR2;
      ST_WAIT: next_state_s = ST_OKAY;
      default: next_state_s = ST_OKAY;
    endcase
  end

  // Output decode of the state being entered, so outputs stay registered.
  always_comb begin
    ready_s = 1'b1;
    resp_s  = 1'b0;
    case (next_state_s)
      ST_OKAY: begin ready_s = 1'b1; resp_s = 1'b0; end
      ST_ERR1: begin ready_s = 1'b0; resp_s = 1'b1; end
      ST_ERR2: begin ready_s = 1'b1; resp_s = 1'b1; end
      ST_WAIT: begin ready_s = 1'b0; resp_s = 1'b0; end
      default: begin ready_s = 1'b1; resp_s = 1'b0; end
    endcase
  end

  // Read data is driven only while a legal read data phase is completing.
  always_comb begin
    if (active_r && !write_r && legal_r && HREADYOUT) begin
      HRDATA = mem[addr_r[IDX_W+1:2]];
    end else begin
      HRDATA = '0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave.sv
module tb_ahb_lite_slave;

`ifdef AHB_LITE_SLAVE_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  // Single slave on the bus: bus ready is this slave's ready.
  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } op_t;

  op_t ops[$];   // transfers still to issue
  op_t sb[$];    // expectations for accepted transfers
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s,
                     input logic [31:0] wd, input logic [31:0] rd, input logic e);
    op_t o;
    o.addr = a; o.wr = w; o.size = s; o.wdata = wd; o.rdata = rd; o.err = e;
    ops.push_back(o);
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'd0; HADDR = 32'd0; HWRITE = 1'b0; HSIZE = 3'd0;
  endtask

  // Issues queued transfers back-to-back; entered and left just after a posedge.
  task automatic run_seq();
    op_t cur;
    op_t dp;
    op_t e;
    bit  dp_v = 1'b0;
    bit  ad_v;
    bit  ready_seen;
    int  stalls = 0;
    int  guard = 0;
    while ((ops.size() > 0 || dp_v) && guard < 200) begin
      guard++;
      ad_v = (ops.size() > 0);
      if (ad_v) begin
        cur = ops[0];
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = cur.addr; HWRITE = cur.wr; HSIZE = cur.size;
      end else begin
        drive_idle();
      end
      HWDATA = dp_v ? dp.wdata : 32'd0;
      @(negedge HCLK);
      if (dp_v) begin
        if (HREADYOUT === 1'b1) begin
          e = sb.pop_front();
          chk($sformatf("resp@%h", e.addr), {31'd0, HRESP}, {31'd0, e.err});
          chk($sformatf("rdata@%h", e.addr), HRDATA, (e.err || e.wr) ? 32'd0 : e.rdata);
          chk($sformatf("stalls@%h", e.addr), stalls, e.err ? 32'd1 : WS);
          dp_v = 1'b0;
        end else begin
          stalls++;
          chk($sformatf("stall_resp@%h", sb[0].addr), {31'd0, HRESP}, {31'd0, sb[0].err});
          if (stalls > 3) begin
            chk("stall_bound", stalls, 32'd3);
            void'(sb.pop_front());
            dp_v = 1'b0;
          end
        end
      end else begin
        chk("idle_ready", {31'd0, HREADYOUT}, 32'd1);
        chk("idle_resp", {31'd0, HRESP}, 32'd0);
        chk("idle_rdata", HRDATA, 32'd0);
      end
      ready_seen = (HREADYOUT === 1'b1);
      @(posedge HCLK); #1;
      if (ready_seen && ad_v) begin
        void'(ops.pop_front());
        sb.push_back(cur);
        dp = cur;
        dp_v = 1'b1;
        stalls = 0;
      end
    end
    if (guard >= 200) begin
      chk("seq_budget", guard, 32'd0);
      ops.delete();
      sb.delete();
    end
    drive_idle();
    HWDATA = 32'd0;
  endtask

  initial begin
    HRESETn = 1'b0; HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0; HWDATA = 32'd0;
    drive_idle();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_ready", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_resp", {31'd0, HRESP}, 32'd0);
    chk("rst_rdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Reset memory content, then write/read-after-write back-to-back.
    add(32'h0, 1'b0, 3'd2, 32'd0, 32'h0000_0000, 1'b0);
    add(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'd0, 1'b0);
    add(32'h10, 1'b0, 3'd2, 32'd0, 32'hDEAD_BEEF, 1'b0);
    run_seq();

    // Byte lanes then a halfword overwrite of the upper half.
    add(32'h20, 1'b1, 3'd0, 32'h1111_1111, 32'd0, 1'b0);
    add(32'h21, 1'b1, 3'd0, 32'h2222_2222, 32'd0, 1'b0);
    add(32'h22, 1'b1, 3'd0, 32'h3333_3333, 32'd0, 1'b0);
    add(32'h23, 1'b1, 3'd0, 32'h4444_4444, 32'd0, 1'b0);
    add(32'h20, 1'b0, 3'd2, 32'd0, 32'h4433_2211, 1'b0);
    add(32'h22, 1'b1, 3'd1, 32'hAAAA_AAAA, 32'd0, 1'b0);
    add(32'h20, 1'b0, 3'd2, 32'd0, 32'hAAAA_2211, 1'b0);
    run_seq();

    // Out of range read, then recovery.
    add(32'h1000, 1'b0, 3'd2, 32'd0, 32'd0, 1'b1);
    add(32'h0, 1'b0, 3'd2, 32'd0, 32'h0000_0000, 1'b0);
    run_seq();

    // Misaligned word write must not land anywhere.
    add(32'h31, 1'b1, 3'd2, 32'h1234_5678, 32'd0, 1'b1);
    add(32'h30, 1'b0, 3'd2, 32'd0, 32'h0000_0000, 1'b0);
    run_seq();

    // Back-to-back errors (odd halfword, oversize), then top-byte boundary.
    add(32'h1, 1'b0, 3'd1, 32'd0, 32'd0, 1'b1);
    add(32'h8, 1'b0, 3'd3, 32'd0, 32'd0, 1'b1);
    add(32'h10, 1'b0, 3'd2, 32'd0, 32'hDEAD_BEEF, 1'b0);
    add(32'hFFF, 1'b1, 3'd0, 32'h5A5A_5A5A, 32'd0, 1'b0);
    add(32'hFFC, 1'b0, 3'd2, 32'd0, 32'h5A00_0000, 1'b0);
    add(32'h1000, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    add(32'hFFC, 1'b0, 3'd2, 32'd0, 32'h5A00_0000, 1'b0);
    run_seq();

    // Word write/read; in the wait-state build each takes one stall.
    add(32'h40, 1'b1, 3'd2, 32'hCAFE_F00D, 32'd0, 1'b0);
    add(32'h40, 1'b0, 3'd2, 32'd0, 32'hCAFE_F00D, 1'b0);
    run_seq();

    // Reset during a write data phase discards the write and clears memory.
    HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h50; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    drive_idle();
    HRESETn = 1'b0; HWDATA = 32'h5555_AAAA;
    @(negedge HCLK);
    chk("rst2_ready", {31'd0, HREADYOUT}, 32'd1);
    chk("rst2_resp", {31'd0, HRESP}, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1; HWDATA = 32'd0;
    add(32'h50, 1'b0, 3'd2, 32'd0, 32'h0000_0000, 1'b0);
    add(32'h10, 1'b0, 3'd2, 32'd0, 32'h0000_0000, 1'b0);
    add(32'h40, 1'b0, 3'd2, 32'd0, 32'h0000_0000, 1'b0);
    run_seq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
